// File: rtl/bp_sacc_coh_flit_arbiter_pkg.sv
// rtl/bp_sacc_coh_flit_arbiter_pkg.sv - shared types and constants for the coherence flit arbiter
package bp_sacc_coh_flit_arbiter_pkg;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_busy = 1'b1
  } bp_sacc_arb_state_e;

  localparam int pkt_count_width_lp = 16;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_sacc_coh_flit_arbiter_rr.sv
// rtl/bp_sacc_coh_flit_arbiter_rr.sv - round-robin winner select; pointer moves past the completed requester
module bp_sacc_coh_flit_arbiter_rr
  import bp_sacc_coh_flit_arbiter_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int lg_num_req_lp = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_req_p-1:0]     v_i,
  input  logic                     yumi_i,
  input  logic [lg_num_req_lp-1:0] yumi_id_i,
  output logic [lg_num_req_lp-1:0] grant_id_o,
  output logic                     grant_v_o
);

  logic [lg_num_req_lp-1:0] ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (yumi_i) begin
      ptr_q <= lg_num_req_lp'((int'(yumi_id_i) + 1) % num_req_p);
    end
  end

  // Scan downward so the candidate closest to the pointer is written last and wins.
  always_comb begin
    int idx;
    idx        = 0;
    grant_v_o  = 1'b0;
    grant_id_o = ptr_q;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % num_req_p;
      if (v_i[idx]) begin
        grant_v_o  = 1'b1;
        grant_id_o = lg_num_req_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bp_sacc_coh_flit_arbiter.sv
// rtl/bp_sacc_coh_flit_arbiter.sv - packet-atomic round-robin flit arbiter onto one coherence link
// BP_SACC_ARB_PKT_COUNT_EN adds per-requester 16-bit completed-packet counters.
module bp_sacc_coh_flit_arbiter
  import bp_sacc_coh_flit_arbiter_pkg::*;
#(
  parameter int  num_req_p     = 2,
  parameter int  flit_width_p  = 64,
  parameter int  len_width_p   = 4,
  parameter int  len_offset_p  = 8,
  localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_req_p*flit_width_p-1:0]       req_data_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  output logic [num_req_p-1:0]                    req_ready_and_o,
  output logic [flit_width_p-1:0]                 link_data_o,
  output logic                                    link_v_o,
  input  logic                                    link_ready_and_i,
  output logic                                    busy_o,
  output logic [lg_num_req_lp-1:0]                grant_id_o,
  output logic [num_req_p*pkt_count_width_lp-1:0] pkt_count_o
);

  bp_sacc_arb_state_e       state_q, state_n;
  logic [len_width_p-1:0]   len_cnt_q, len_cnt_n;
  logic [lg_num_req_lp-1:0] grant_q, grant_n;
  logic [lg_num_req_lp-1:0] sel_id;
  logic [lg_num_req_lp-1:0] rr_id;
  logic                     rr_v;
  logic                     hs;
  logic [len_width_p-1:0]   hdr_len;
  logic                     yumi;
  logic [lg_num_req_lp-1:0] yumi_id;
  logic [flit_width_p-1:0]  req_data_a [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign req_data_a[g] = req_data_i[g*flit_width_p +: flit_width_p];
  end

  bp_sacc_coh_flit_arbiter_rr #(
    .num_req_p     (num_req_p),
    .lg_num_req_lp (lg_num_req_lp)
  ) rr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (req_v_i),
    .yumi_i     (yumi),
    .yumi_id_i  (yumi_id),
    .grant_id_o (rr_id),
    .grant_v_o  (rr_v)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      len_cnt_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_n;
      len_cnt_q <= len_cnt_n;
      grant_q   <= grant_n;
    end
  end

  // Outputs are gated during reset so a partial packet cannot leak a handshake.
  always_comb begin
    state_n         = state_q;
    len_cnt_n       = len_cnt_q;
    grant_n         = grant_q;
    sel_id          = grant_q;
    link_v_o        = 1'b0;
    req_ready_and_o = '0;
    busy_o          = 1'b0;
    grant_id_o      = grant_q;
    yumi            = 1'b0;
    yumi_id         = grant_q;

    case (state_q)
      e_idle: begin
        if (rr_v) begin
          sel_id                  = rr_id;
          grant_id_o              = rr_id;
          grant_n                 = rr_id;
          link_v_o                = ~reset_i;
          req_ready_and_o[rr_id]  = link_ready_and_i & ~reset_i;
        end
      end
      e_busy: begin
        busy_o                   = 1'b1;
        link_v_o                 = req_v_i[grant_q] & ~reset_i;
        req_ready_and_o[grant_q] = link_ready_and_i & ~reset_i;
      end
      default: ;
    endcase

    link_data_o = req_data_a[sel_id];
    hdr_len     = link_data_o[len_offset_p +: len_width_p];
    hs          = link_v_o & link_ready_and_i;

    if (state_q == e_idle) begin
      if (hs) begin
        if (hdr_len == '0) begin
          yumi    = 1'b1;
          yumi_id = rr_id;
        end else begin
          state_n   = e_busy;
          len_cnt_n = hdr_len;
        end
      end
    end else if (hs) begin
      len_cnt_n = len_cnt_q - 1'b1;
      if (len_cnt_q == len_width_p'(1)) begin
        state_n = e_idle;
        yumi    = 1'b1;
        yumi_id = grant_q;
      end
    end
  end

`ifdef BP_SACC_ARB_PKT_COUNT_EN
  logic [pkt_count_width_lp-1:0] pkt_cnt_q [num_req_p];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (reset_i) begin
        pkt_cnt_q[i] <= '0;
      end else if (yumi && (yumi_id == lg_num_req_lp'(i))) begin
        pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < num_req_p; g++) begin : g_cnt
    assign pkt_count_o[g*pkt_count_width_lp +: pkt_count_width_lp] = pkt_cnt_q[g];
  end
`else
  assign pkt_count_o = '0;
`endif

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_busy) |-> (len_cnt_q != '0));
  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_and_o));
`endif

endmodule

// File: tb/tb_bp_sacc_coh_flit_arbiter.sv
// tb/tb_bp_sacc_coh_flit_arbiter.sv - scoreboard bench for the coherence flit arbiter
module tb_bp_sacc_coh_flit_arbiter;

  localparam int n_lp = 3;
  localparam int w_lp = 64;

  typedef struct packed {
    logic [1:0]  id;
    logic        busy;
    logic [63:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [n_lp*w_lp-1:0] req_data_i;
  logic [n_lp-1:0]   req_v_i;
  logic [n_lp-1:0]   req_ready_and_o;
  logic [w_lp-1:0]   link_data_o;
  logic              link_v_o;
  logic              link_ready_and_i;
  logic              busy_o;
  logic [1:0]        grant_id_o;
  logic [n_lp*16-1:0] pkt_count_o;

  int checks = 0;
  int errors = 0;
  int seq_ctr = 0;
  int n;
  logic [n_lp-1:0] mask;
  logic [63:0] src [n_lp][$];
  exp_t exp_q[$];
  logic [63:0] exp_cnt;

  bp_sacc_coh_flit_arbiter #(
    .num_req_p    (n_lp),
    .flit_width_p (w_lp),
    .len_width_p  (4),
    .len_offset_p (8)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_data_i       (req_data_i),
    .req_v_i          (req_v_i),
    .req_ready_and_o  (req_ready_and_o),
    .link_data_o      (link_data_o),
    .link_v_o         (link_v_o),
    .link_ready_and_i (link_ready_and_i),
    .busy_o           (busy_o),
    .grant_id_o       (grant_id_o),
    .pkt_count_o      (pkt_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < n_lp; r++) begin
      req_v_i[r] = mask[r] && (src[r].size() > 0);
      req_data_i[r*w_lp +: w_lp] = (src[r].size() > 0) ? src[r][0] : 64'h0;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Header: len at [11:8], bit 48 marks header, id in the top byte.
  task automatic send(input int r, input int len);
    for (int k = 0; k <= len; k++) begin
      logic [63:0] f;
      exp_t e;
      f = {8'(r), 7'd0, (k == 0), 32'(seq_ctr), 4'h0, 4'((k == 0) ? len : 0), 8'h0};
      seq_ctr++;
      src[r].push_back(f);
      e.id = 2'(r);
      e.busy = (k != 0);
      e.data = f;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int r = 0; r < n_lp; r++) src[r].delete();
    exp_q.delete();
  endtask

  task automatic step();
    logic [n_lp-1:0] fire;
    exp_t e;
    @(negedge clk);
    if (link_v_o && link_ready_and_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", link_data_o, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("data", link_data_o, e.data);
        check("grant", 64'(grant_id_o), 64'(e.id));
        check("busy", 64'(busy_o), 64'(e.busy));
      end
    end
    fire = req_v_i & req_ready_and_o;
    sync();
    for (int r = 0; r < n_lp; r++) if (fire[r]) void'(src[r].pop_front());
    drive();
  endtask

  task automatic run(output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      step();
      cycles++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic apply_reset(input int cyc);
    reset_i = 1'b1;
    clear_all();
    drive();
    repeat (cyc) sync();
    reset_i = 1'b0;
    mask = '1;
    link_ready_and_i = 1'b1;
    drive();
  endtask

  initial begin
    reset_i = 1'b1;
    req_v_i = '0;
    req_data_i = '0;
    link_ready_and_i = 1'b1;
    mask = '1;
    apply_reset(2);

    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_link_v", 64'(link_v_o), 64'd0);
    check("rst_ready", 64'(req_ready_and_o), 64'd0);
    check("rst_grant", 64'(grant_id_o), 64'd0);
    check("rst_pkt_count", 64'(pkt_count_o), 64'd0);
    sync();

    // Three single-flit packets back to back from req0.
    for (int k = 0; k < 3; k++) send(0, 0);
    drive();
    run(n);
    check("t1_cycles", 64'(n), 64'd3);
`ifdef BP_SACC_ARB_PKT_COUNT_EN
    exp_cnt = 64'd3;
`else
    exp_cnt = 64'd0;
`endif
    check("t1_pkt_count0", 64'(pkt_count_o[15:0]), exp_cnt);

    // Two multi-flit packets, no interleave, no bubble.
    apply_reset(1);
    send(0, 2);
    send(1, 1);
    drive();
    run(n);
    check("t2_cycles", 64'(n), 64'd5);

    // Mid-body stall on a len=3 packet with a competing requester.
    apply_reset(1);
    send(0, 3);
    send(1, 0);
    drive();
    step();
    step();
    link_ready_and_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_stall_v", 64'(link_v_o), 64'd1);
      check("t3_stall_data", link_data_o, exp_q[0].data);
      check("t3_stall_ready", 64'(req_ready_and_o), 64'd0);
      check("t3_stall_busy", 64'(busy_o), 64'd1);
      sync();
    end
    link_ready_and_i = 1'b1;
    run(n);
    check("t3_cycles", 64'(n), 64'd3);

    // Fairness: two requesters alternate, then three rotate.
    apply_reset(1);
    for (int k = 0; k < 4; k++) begin
      send(0, 0);
      send(1, 0);
    end
    drive();
    run(n);
    check("t4_cycles", 64'(n), 64'd8);
    apply_reset(1);
    for (int k = 0; k < 2; k++) begin
      send(0, 0);
      send(1, 0);
      send(2, 0);
    end
    drive();
    run(n);
    check("t4b_cycles", 64'(n), 64'd6);

    // Reset mid-packet after two flits of a len=4 packet.
    apply_reset(1);
    send(1, 0);
    drive();
    run(n);
    send(0, 4);
    drive();
    step();
    step();
    apply_reset(1);
    @(negedge clk);
    check("t5_busy", 64'(busy_o), 64'd0);
    check("t5_link_v", 64'(link_v_o), 64'd0);
    sync();
    send(0, 0);
    send(1, 0);
    drive();
    run(n);

    // Stalled header keeps its grant when another requester arrives.
    apply_reset(1);
    link_ready_and_i = 1'b0;
    mask = 3'b001;
    send(0, 1);
    send(1, 0);
    drive();
    step();
    mask = 3'b011;
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_grant", 64'(grant_id_o), 64'd0);
      check("t6_hdr", link_data_o, exp_q[0].data);
      check("t6_ready", 64'(req_ready_and_o), 64'd0);
      sync();
    end
    link_ready_and_i = 1'b1;
    run(n);
    check("t6_cycles", 64'(n), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
